seg7_scan_capture: RTL and testbench

Receive-side counterpart of the 8-digit multiplexed seven-segment display driver. The block watches the active-low anode lines an0..an7 and segment lines segA..segG and rebuilds the eight hex digits being shown. It also reports the scan direction and flags malformed frames. Captured digits can be read back through a select/number port that mirrors the driver's write port, so a bench or on-chip checker can confirm what the display actually showed.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_glyph_decode.sv | 22 ++
 rtl/seg7_scan_capture.sv | 158 +++++++++++++++
 tb/tb_seg7_scan_capture.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan capture block: glyph table,
// capture FSM states and digit count.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  // Active-high segment patterns (bit6=A .. bit0=G); entry k is the glyph for hex value k.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse lookup: active-high segment pattern to hex value,
// with a flag telling whether the pattern is one of the 16 hex glyphs.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] value
);

  always_comb begin
    legal = 1'b0;
    value = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (seg == GLYPH_TABLE[k]) begin
        legal = 1'b1;
        value = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Rebuilds the eight hex digits shown on a multiplexed seven-segment display
// from its anode/segment pins, tracks scan direction and flags bad frames.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       an0,
  input  logic       an1,
  input  logic       an2,
  input  logic       an3,
  input  logic       an4,
  input  logic       an5,
  input  logic       an6,
  input  logic       an7,
  input  logic       segA,
  input  logic       segB,
  input  logic       segC,
  input  logic       segD,
  input  logic       segE,
  input  logic       segF,
  input  logic       segG,
  input  logic [2:0] rd_sel,
  output logic [3:0] rd_num,
  output logic       rd_valid,
  output logic       frame_done,
  output logic       scan_dir,
  output logic       glyph_err,
  output logic       multi_an_err
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [14:0] pins;
  logic [14:0] sync_p0, sync_p1;
  logic [14:0] pat_q;
  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  digits [NUM_DIGITS];
  logic [7:0]  valid;
  logic [7:0]  frame_mask;
  logic [2:0]  prev_idx;

  logic        any_an_low;
  logic [7:0]  an_act;
  logic        one_hot;
  logic [2:0]  idx;
  logic        legal;
  logic [3:0]  value;

  // Pattern layout: [14:7] = an7..an0, [6:0] = segA..segG, all still active-low.
  assign pins = {an7, an6, an5, an4, an3, an2, an1, an0,
                 segA, segB, segC, segD, segE, segF, segG};

  assign any_an_low = ~&sync_p1[14:7];
  assign an_act     = ~pat_q[14:7];
  assign one_hot    = (an_act != 8'd0) && ((an_act & (an_act - 8'd1)) == 8'd0);
  assign frame_done = &frame_mask;

  always_comb begin
    idx = 3'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (an_act[k]) idx = 3'(k);
    end
  end

  seg7_glyph_decode u_decode (
    .seg   (~pat_q[6:0]),
    .legal (legal),
    .value (value)
  );

  // Stage p0/p1: two-flop synchronizer, idling at the blank (all-high) level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= pins;
      sync_p1 <= sync_p0;
    end
  end

  // Capture FSM, digit register file and read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pat_q        <= '1;
      cnt          <= 8'd0;
      valid        <= 8'd0;
      frame_mask   <= 8'd0;
      prev_idx     <= 3'd0;
      scan_dir     <= 1'b1;
      glyph_err    <= 1'b0;
      multi_an_err <= 1'b0;
      rd_num       <= 4'd0;
      rd_valid     <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) digits[k] <= 4'd0;
    end else begin
      glyph_err    <= 1'b0;
      multi_an_err <= 1'b0;
      rd_num       <= digits[rd_sel];
      rd_valid     <= valid[rd_sel];
      if (frame_done) frame_mask <= 8'd0;

      case (state)
        IDLE: begin
          if (any_an_low) begin
            state <= SETTLE;
            pat_q <= sync_p1;
            cnt   <= 8'd1;
          end
        end
        SETTLE: begin
          if (!any_an_low) begin
            state <= IDLE;
          end else if (sync_p1 != pat_q) begin
            pat_q <= sync_p1;
            cnt   <= 8'd1;
          end else if (cnt >= CNT_LAST) begin
            // Errors are raised now so they are high exactly during CAPTURE.
            state        <= CAPTURE;
            glyph_err    <= one_hot && !legal;
            multi_an_err <= !one_hot;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CAPTURE: begin
          state <= HOLD;
          if (one_hot && legal) begin
            digits[idx]     <= value;
            valid[idx]      <= 1'b1;
            frame_mask[idx] <= 1'b1;
            prev_idx        <= idx;
            if (idx == prev_idx + 3'd1) scan_dir <= 1'b1;
            else if (idx == prev_idx - 3'd1) scan_dir <= 1'b0;
          end else if (one_hot) begin
            valid[idx] <= 1'b0;
          end
        end
        HOLD: begin
          if (!any_an_low) begin
            state <= IDLE;
          end else if (sync_p1 != pat_q) begin
            state <= SETTLE;
            pat_q <= sync_p1;
            cnt   <= 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture: table-driven scans with a
// scoreboard queue plus hand-written glitch, fault, latency and reset sequences.
module tb_seg7_scan_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] an_n;
  logic [6:0] seg_n;
  logic [2:0] rd_sel;
  logic [3:0] rd_num;
  logic       rd_valid, frame_done, scan_dir, glyph_err, multi_an_err;

  int tests = 0;
  int fails = 0;
  int n_fd = 0, n_ge = 0, n_me = 0;

  typedef struct {
    logic [2:0] idx;
    logic [6:0] glyph;
    int         val;
  } vec_t;

  typedef struct {
    int idx;
    int val;
  } cap_t;

  vec_t vecs [16];
  cap_t sbq [$];
  int   exp_num [8];
  int   exp_vld [8];

  always #5 clk = ~clk;

  seg7_scan_capture #(.STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .an0          (an_n[0]),
    .an1          (an_n[1]),
    .an2          (an_n[2]),
    .an3          (an_n[3]),
    .an4          (an_n[4]),
    .an5          (an_n[5]),
    .an6          (an_n[6]),
    .an7          (an_n[7]),
    .segA         (seg_n[6]),
    .segB         (seg_n[5]),
    .segC         (seg_n[4]),
    .segD         (seg_n[3]),
    .segE         (seg_n[2]),
    .segF         (seg_n[1]),
    .segG         (seg_n[0]),
    .rd_sel       (rd_sel),
    .rd_num       (rd_num),
    .rd_valid     (rd_valid),
    .frame_done   (frame_done),
    .scan_dir     (scan_dir),
    .glyph_err    (glyph_err),
    .multi_an_err (multi_an_err)
  );

  always @(negedge clk) begin
    if (frame_done)   n_fd++;
    if (glyph_err)    n_ge++;
    if (multi_an_err) n_me++;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive anodes (active-low mask) and an active-high glyph onto the pins.
  task automatic drive(input logic [7:0] an_mask_n, input logic [6:0] glyph_ah);
    an_n  = an_mask_n;
    seg_n = ~glyph_ah;
  endtask

  task automatic blank(input int cycles);
    an_n  = 8'hFF;
    seg_n = 7'h7F;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic read_digit(input int i, output int num, output int vld);
    rd_sel = 3'(i);
    @(posedge clk);
    @(negedge clk);
    num = int'(rd_num);
    vld = int'(rd_valid);
  endtask

  task automatic readback_all(input string tag);
    int num, vld;
    for (int i = 0; i < 8; i++) begin
      read_digit(i, num, vld);
      check($sformatf("%s num[%0d]", tag, i), num, exp_num[i]);
      check($sformatf("%s vld[%0d]", tag, i), vld, exp_vld[i]);
    end
  endtask

  task automatic drain_scoreboard(input string tag);
    cap_t c;
    int   num, vld;
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      read_digit(c.idx, num, vld);
      check($sformatf("%s num[%0d]", tag, c.idx), num, c.val);
      check($sformatf("%s vld[%0d]", tag, c.idx), vld, 1);
    end
  endtask

  task automatic run_vectors(input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      drive(~(8'd1 << vecs[k].idx), vecs[k].glyph);
      repeat (10) @(negedge clk);
      sbq.push_back('{idx: int'(vecs[k].idx), val: vecs[k].val});
      exp_num[vecs[k].idx] = vecs[k].val;
      exp_vld[vecs[k].idx] = 1;
    end
    blank(12);
  endtask

  initial begin
    int fd0, ge0, me0, num, vld;

    // Ascending 1..8 on an0..an7, then descending F,E,d,C,b,A,9,0 on an7..an0.
    vecs[0]  = '{3'd0, 7'b0110000, 1};
    vecs[1]  = '{3'd1, 7'b1101101, 2};
    vecs[2]  = '{3'd2, 7'b1111001, 3};
    vecs[3]  = '{3'd3, 7'b0110011, 4};
    vecs[4]  = '{3'd4, 7'b1011011, 5};
    vecs[5]  = '{3'd5, 7'b1011111, 6};
    vecs[6]  = '{3'd6, 7'b1110000, 7};
    vecs[7]  = '{3'd7, 7'b1111111, 8};
    vecs[8]  = '{3'd7, 7'b1000111, 15};
    vecs[9]  = '{3'd6, 7'b1001111, 14};
    vecs[10] = '{3'd5, 7'b0111101, 13};
    vecs[11] = '{3'd4, 7'b1001110, 12};
    vecs[12] = '{3'd3, 7'b0011111, 11};
    vecs[13] = '{3'd2, 7'b1110111, 10};
    vecs[14] = '{3'd1, 7'b1111011, 9};
    vecs[15] = '{3'd0, 7'b1111110, 0};
    for (int i = 0; i < 8; i++) begin
      exp_num[i] = 0;
      exp_vld[i] = 0;
    end

    reset  = 1'b0;
    rd_sel = 3'd0;
    an_n   = 8'hFF;
    seg_n  = 7'h7F;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    check("reset rd_num", int'(rd_num), 0);
    check("reset rd_valid", int'(rd_valid), 0);
    check("reset frame_done", int'(frame_done), 0);
    check("reset scan_dir", int'(scan_dir), 1);
    check("reset glyph_err", int'(glyph_err), 0);
    check("reset multi_an_err", int'(multi_an_err), 0);
    readback_all("reset");

    fd0 = n_fd;
    run_vectors(0, 8);
    check("asc frame_done pulses", n_fd - fd0, 1);
    check("asc scan_dir", int'(scan_dir), 1);
    drain_scoreboard("asc");

    fd0 = n_fd;
    run_vectors(8, 8);
    check("desc frame_done pulses", n_fd - fd0, 1);
    check("desc scan_dir", int'(scan_dir), 0);
    drain_scoreboard("desc");

    // Latency and same-cycle write/read: digit 6 holds E, now shows 2.
    rd_sel = 3'd6;
    @(negedge clk);
    drive(~8'h40, 7'b1101101);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("latency old value", int'(rd_num), 14);
    @(posedge clk);
    @(negedge clk);
    check("latency new value", int'(rd_num), 2);
    exp_num[6] = 2;
    blank(8);

    // Glitch on an3 for STABLE_CYCLES-1 cycles showing 5.
    ge0 = n_ge; me0 = n_me; fd0 = n_fd;
    drive(~8'h08, 7'b1011011);
    repeat (3) @(negedge clk);
    blank(10);
    check("glitch glyph_err", n_ge - ge0, 0);
    check("glitch multi_an_err", n_me - me0, 0);
    readback_all("glitch");

    // Illegal pattern on an2.
    ge0 = n_ge; me0 = n_me;
    drive(~8'h04, 7'b1010101);
    repeat (10) @(negedge clk);
    blank(8);
    check("illegal glyph_err pulses", n_ge - ge0, 1);
    check("illegal multi_an_err", n_me - me0, 0);
    exp_vld[2] = 0;
    readback_all("illegal");

    // Two anodes low together.
    ge0 = n_ge; me0 = n_me;
    drive(~8'h22, 7'b1110000);
    repeat (10) @(negedge clk);
    blank(8);
    check("multi multi_an_err pulses", n_me - me0, 1);
    check("multi glyph_err", n_ge - ge0, 0);
    check("faults frame_done", n_fd - fd0, 0);
    readback_all("multi");

    // Reset in the middle of a dwell on an4 showing 3.
    rd_sel = 3'd4;
    drive(~8'h10, 7'b1111001);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset rd_num", int'(rd_num), 0);
    check("midreset rd_valid", int'(rd_valid), 0);
    check("midreset scan_dir", int'(scan_dir), 1);
    check("midreset frame_done", int'(frame_done), 0);
    check("midreset glyph_err", int'(glyph_err), 0);
    check("midreset multi_an_err", int'(multi_an_err), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post-reset early rd_valid", int'(rd_valid), 0);
    check("post-reset early rd_num", int'(rd_num), 0);
    repeat (5) @(negedge clk);
    check("post-reset capture rd_valid", int'(rd_valid), 1);
    check("post-reset capture rd_num", int'(rd_num), 3);
    blank(6);
    read_digit(0, num, vld);
    check("post-reset num[0]", num, 0);
    check("post-reset vld[0]", vld, 0);
    check("post-reset scan_dir", int'(scan_dir), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
